// File: rtl/golay_enc_stream_if.sv
// Streaming handshake bundle for the Golay(24,12) encoder: data words in, codewords out.
interface golay_enc_stream_if;
    logic [11:0] DIN;
    logic        DIN_VLD;
    logic        DIN_RDY;
    logic [23:0] CW;
    logic        CW_VLD;
    logic        CW_RDY;

    // Source of data words and sink of codewords
    modport master (
        output DIN, DIN_VLD, CW_RDY,
        input  DIN_RDY, CW, CW_VLD
    );

    // Encoder side
    modport slave (
        input  DIN, DIN_VLD, CW_RDY,
        output DIN_RDY, CW, CW_VLD
    );
endinterface

// File: rtl/golay_enc_stream.sv
// Golay(24,12) streaming encoder: two-stage parity pipeline feeding a credit-controlled
// output FIFO, with a wrapping count of delivered codewords.
module golay_enc_stream #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 FLUSH,
    golay_enc_stream_if.slave    bus,
    output logic [15:0]          WCNT
);
    localparam int DATA_W = 12;
    localparam int AW     = $clog2(FIFO_DEPTH);

    // Generator rows BR1 (MSB slice) .. BR12 (LSB slice); DIN[12-i] selects BRi
    localparam logic [12*DATA_W-1:0] ROWS = {
        12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
        12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71
    };

    // Partial parity over rows first..last
    function automatic logic [DATA_W-1:0] parity_rows(input logic [DATA_W-1:0] d,
                                                      input int first, input int last);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int i = 1; i <= 12; i++) begin
            if (i >= first && i <= last && d[12-i]) begin
                p = p ^ ROWS[(12-i)*DATA_W +: DATA_W];
            end
        end
        return p;
    endfunction

    logic [DATA_W-1:0] din_p1;
    logic [DATA_W-1:0] pa_p1;
    logic [DATA_W-1:0] pb_p1;
    logic              vld_p1;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         occ;
    logic                rdy_en;
    logic [15:0]         wcnt;

    logic                in_xfer;
    logic                wr_en;
    logic                rd_en;
    logic [AW+1:0]       credit;

    // Slots committed downstream: FIFO entries plus the word held in stage 1
    assign credit      = {1'b0, occ} + (AW+2)'(vld_p1);
    assign bus.DIN_RDY = rdy_en && !FLUSH && (credit < (AW+2)'(FIFO_DEPTH));
    assign bus.CW_VLD  = (occ != '0);
    // Storage is not reset, so the head is masked while empty
    assign bus.CW      = bus.CW_VLD ? mem[rd_ptr] : '0;
    assign WCNT        = wcnt;

    assign in_xfer = bus.DIN_VLD && bus.DIN_RDY;
    assign wr_en   = vld_p1 && !FLUSH;
    assign rd_en   = bus.CW_VLD && bus.CW_RDY && !FLUSH;

    // Stage 1 valid: set by an accepted input word, cleared by flush or reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1 <= 1'b0;
        end else if (FLUSH) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_xfer;
        end
    end

    // Stage 1 data: capture the word and both half-parities
    always_ff @(posedge CLK) begin
        if (in_xfer) begin
            din_p1 <= bus.DIN;
            pa_p1  <= parity_rows(bus.DIN, 1, 6);
            pb_p1  <= parity_rows(bus.DIN, 7, 12);
        end
    end

    // Stage 2: combine half-parities and write the codeword into the FIFO
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= {din_p1, pa_p1 ^ pb_p1};
        end
    end

    // FIFO pointers and occupancy; simultaneous write and read leave occupancy unchanged
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Delivered-codeword counter, wraps naturally at 16 bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wcnt <= '0;
        end else if (FLUSH) begin
            wcnt <= '0;
        end else if (rd_en) begin
            wcnt <= wcnt + 16'd1;
        end
    end

    // Input enable: held low through reset, rises on the first edge afterwards
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end
endmodule

// File: tb/tb_golay_enc_stream.sv
// Self-checking bench for golay_enc_stream: scoreboard of reference codewords plus
// directed latency, backpressure, flush, reset, throughput and counter-wrap checks.
module tb_golay_enc_stream;
    logic        CLK;
    logic        RST_N;
    logic        FLUSH;
    logic [15:0] wcnt;
    logic        rnd_mode;
    logic        rdy_force;
    logic        rdy_rand;

    int          n_chk;
    int          n_pass;
    int          n_out;
    logic [15:0] exp_wcnt;
    logic [23:0] q[$];
    logic        prev_hold;
    logic [23:0] prev_cw;

    golay_enc_stream_if bus();

    golay_enc_stream #(.FIFO_DEPTH(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .FLUSH (FLUSH),
        .bus   (bus),
        .WCNT  (wcnt)
    );

    assign bus.CW_RDY = rnd_mode ? rdy_rand : rdy_force;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #2;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference encoder: bit DIN[j] selects row BR(12-j)
    function automatic logic [23:0] ref_cw(input logic [11:0] d);
        logic [11:0] br [12];
        logic [11:0] p;
        br = '{12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
               12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71};
        p = '0;
        for (int j = 0; j < 12; j++) begin
            if (d[j]) p = p ^ br[11-j];
        end
        return {d, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor: sample between edges, transfers happen on the following edge
    always @(negedge CLK) begin
        logic [23:0] e;
        if (!RST_N || FLUSH) begin
            q.delete();
            exp_wcnt  = '0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && bus.CW_VLD) chk("cw_hold", 32'(bus.CW), 32'(prev_cw));
            if (bus.DIN_VLD && bus.DIN_RDY) q.push_back(ref_cw(bus.DIN));
            if (bus.CW_VLD && bus.CW_RDY) begin
                chk("sb_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_cw", 32'(bus.CW), 32'(e));
                end
                chk("cw_weight", 32'(($countones(bus.CW) >= 8) || (bus.CW == '0)), 32'd1);
                exp_wcnt = exp_wcnt + 16'd1;
                n_out++;
            end
            prev_hold = bus.CW_VLD && !bus.CW_RDY;
            prev_cw   = bus.CW;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        bit acc;
        int n;
        bus.DIN     = d;
        bus.DIN_VLD = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
            @(negedge CLK);
            acc = bus.DIN_RDY;
            step();
            n++;
        end
        if (!acc) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge CLK);
            if (q.size() == 0 && !bus.CW_VLD) break;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        step();
    endtask

    task automatic wait_cw(input string tag, input logic [23:0] exp);
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus.CW_VLD && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(bus.CW), 32'(exp));
    endtask

    task automatic do_flush();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
    endtask

    initial begin
        logic [11:0] vin  [4];
        logic [23:0] vout [4];
        int acc;
        int outs;
        int base;

        vin  = '{12'h800, 12'h001, 12'hC00, 12'h000};
        vout = '{24'h8007FF, 24'h001B71, 24'hC0091D, 24'h000000};
        n_chk = 0; n_pass = 0; n_out = 0;
        exp_wcnt = '0; prev_hold = 1'b0; prev_cw = '0;
        RST_N = 1'b0; FLUSH = 1'b0;
        rnd_mode = 1'b0; rdy_force = 1'b1; rdy_rand = 1'b0;
        bus.DIN = '0; bus.DIN_VLD = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_din_rdy", 32'(bus.DIN_RDY), 32'd0);
        chk("rst_cw_vld", 32'(bus.CW_VLD), 32'd0);
        chk("rst_wcnt", 32'(wcnt), 32'd0);
        chk("rst_cw", 32'(bus.CW), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(bus.DIN_RDY), 32'd0);
        step();
        chk("rdy_first_edge", 32'(bus.DIN_RDY), 32'd1);

        // Known vectors with two-edge latency
        for (int k = 0; k < 4; k++) begin
            bus.DIN = vin[k];
            bus.DIN_VLD = 1'b1;
            @(negedge CLK);
            chk("vec_rdy", 32'(bus.DIN_RDY), 32'd1);
            step();
            bus.DIN_VLD = 1'b0;
            @(negedge CLK);
            chk("vec_lat_n1", 32'(bus.CW_VLD), 32'd0);
            step();
            @(negedge CLK);
            chk("vec_lat_n2", 32'(bus.CW_VLD), 32'd1);
            chk("vec_cw", 32'(bus.CW), 32'(vout[k]));
            step();
        end
        chk("vec_wcnt", 32'(wcnt), 32'd4);

        // Backpressure: exactly FIFO_DEPTH words accepted, then in-order burst
        do_flush();
        rdy_force = 1'b0;
        acc = 0;
        bus.DIN = 12'h100;
        bus.DIN_VLD = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            if (bus.DIN_RDY) acc++;
            step();
            bus.DIN = 12'h100 + 12'(acc);
        end
        bus.DIN_VLD = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        @(negedge CLK);
        chk("bp_rdy_low", 32'(bus.DIN_RDY), 32'd0);
        chk("bp_head", 32'(bus.CW), 32'(ref_cw(12'h100)));
        step();
        rdy_force = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("bp_b2b_vld", 32'(bus.CW_VLD), 32'd1);
            step();
        end
        @(negedge CLK);
        chk("bp_empty", 32'(bus.CW_VLD), 32'd0);
        chk("bp_wcnt", 32'(wcnt), 32'd4);
        step();

        // Flush with 3 words in the FIFO and 1 in stage 1
        rdy_force = 1'b0;
        for (int k = 0; k < 4; k++) send(12'h200 + 12'(k));
        bus.DIN_VLD = 1'b0;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_cw_vld", 32'(bus.CW_VLD), 32'd0);
        chk("flush_wcnt", 32'(wcnt), 32'd0);
        step();
        @(negedge CLK);
        chk("flush_no_late", 32'(bus.CW_VLD), 32'd0);
        step();
        rdy_force = 1'b1;
        send(12'h2AA);
        bus.DIN_VLD = 1'b0;
        wait_cw("flush_next_first", ref_cw(12'h2AA));
        drain();

        // Asynchronous reset with 3 words in the FIFO and 1 in stage 1
        rdy_force = 1'b0;
        for (int k = 0; k < 4; k++) send(12'h300 + 12'(k));
        bus.DIN_VLD = 1'b0;
        chk("pre_rst_cw_vld", 32'(bus.CW_VLD), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("arst_cw_vld", 32'(bus.CW_VLD), 32'd0);
        chk("arst_wcnt", 32'(wcnt), 32'd0);
        chk("arst_din_rdy", 32'(bus.DIN_RDY), 32'd0);
        step();
        @(negedge CLK);
        RST_N = 1'b1;
        rdy_force = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("arst_no_pulse", 32'(bus.CW_VLD), 32'd0);
        end
        step();
        send(12'h3CC);
        bus.DIN_VLD = 1'b0;
        wait_cw("arst_next_first", ref_cw(12'h3CC));
        drain();

        // Simultaneous input and output with a partly full FIFO
        rdy_force = 1'b0;
        for (int k = 0; k < 3; k++) send(12'h400 + 12'(k));
        bus.DIN_VLD = 1'b0;
        step();
        step();
        rdy_force = 1'b1;
        acc = 0;
        outs = 0;
        bus.DIN = 12'h410;
        bus.DIN_VLD = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            if (bus.DIN_RDY) acc++;
            if (bus.CW_VLD) outs++;
            step();
            bus.DIN = 12'h410 + 12'(acc);
        end
        bus.DIN_VLD = 1'b0;
        chk("sim_accepts", 32'(acc), 32'd12);
        chk("sim_outputs", 32'(outs), 32'd12);
        drain();

        // Exhaustive encode with random output backpressure
        base = n_out;
        rnd_mode = 1'b1;
        for (int i = 0; i < 4096; i++) send(12'(i));
        bus.DIN_VLD = 1'b0;
        drain();
        rnd_mode = 1'b0;
        chk("exh_count", 32'(n_out - base), 32'd4096);

        // Counter wrap
        do_flush();
        for (int i = 0; i < 65535; i++) send(12'(i));
        bus.DIN_VLD = 1'b0;
        drain();
        chk("wcnt_ffff", 32'(wcnt), 32'hFFFF);
        chk("wcnt_model", 32'(wcnt), 32'(exp_wcnt));
        send(12'h555);
        bus.DIN_VLD = 1'b0;
        drain();
        chk("wcnt_wrap", 32'(wcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
